// File: rtl/mode_input_router.sv
// Steers debounced function buttons to the active mode's pulse slice, cycles the mode on
// the mode button, and adds release lockout, auto-repeat and a mode-change strobe.
module mode_input_router #(
    parameter int                  NUM_MODES     = 3,
    parameter int                  NUM_BTNS      = 4,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK   = 4'b0001,
    parameter int                  REPEAT_DELAY  = 50_000_000,
    parameter int                  REPEAT_PERIOD = 10_000_000,
    localparam int                 MW            = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          mode_btn_i,
    input  logic [NUM_BTNS-1:0]           btn_i,
    output logic [MW-1:0]                 mode_o,
    output logic                          mode_change_o,
    output logic                          lockout_o,
    output logic [NUM_MODES*NUM_BTNS-1:0] pulse_o
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(RPT_MAX + 1);

    logic [MW-1:0]                 mode_q, mode_d;
    logic                          mode_btn_q;
    logic [NUM_BTNS-1:0]           btn_q;
    logic                          mode_change_q, mode_change_d;
    logic                          lockout_q, lockout_d;
    logic [NUM_MODES*NUM_BTNS-1:0] pulse_q, pulse_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          phase_q, phase_d;

    logic                mode_rise;
    logic [NUM_BTNS-1:0] btn_rise;
    logic                one_held;
    logic                rpt_ok;
    logic                rpt_fire;
    logic [CW-1:0]       rpt_target;
    logic [NUM_BTNS-1:0] slice;

    always_comb begin
        mode_rise  = mode_btn_i & ~mode_btn_q;
        btn_rise   = btn_i & ~btn_q;
        one_held   = (btn_i != '0) && ((btn_i & (btn_i - NUM_BTNS'(1))) == '0);
        rpt_ok     = one_held && ((btn_i & REPEAT_MASK) != '0) && !lockout_q && !mode_rise;
        // phase_q=0 waits out the initial delay, phase_q=1 the shorter repeat period
        rpt_target = phase_q ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1);

        mode_d        = mode_q;
        mode_change_d = 1'b0;
        lockout_d     = lockout_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        rpt_fire      = 1'b0;
        slice         = '0;
        pulse_d       = '0;

        if (mode_rise) begin
            mode_d        = (mode_q == MW'(NUM_MODES - 1)) ? '0 : mode_q + MW'(1);
            mode_change_d = 1'b1;
            lockout_d     = 1'b1;
        end else if (btn_i == '0) begin
            lockout_d = 1'b0;
        end

        if ((btn_i != btn_q) || !rpt_ok) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == rpt_target) begin
            cnt_d    = '0;
            phase_d  = 1'b1;
            rpt_fire = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (!lockout_q && !mode_rise) begin
            slice = btn_rise | (rpt_fire ? btn_i : '0);
        end

        for (int unsigned m = 0; m < NUM_MODES; m++) begin
            if (mode_q == MW'(m)) begin
                pulse_d[m*NUM_BTNS +: NUM_BTNS] = slice;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_q        <= '0;
            mode_btn_q    <= 1'b0;
            btn_q         <= '0;
            mode_change_q <= 1'b0;
            lockout_q     <= 1'b1;
            pulse_q       <= '0;
            cnt_q         <= '0;
            phase_q       <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            mode_btn_q    <= mode_btn_i;
            btn_q         <= btn_i;
            mode_change_q <= mode_change_d;
            lockout_q     <= lockout_d;
            pulse_q       <= pulse_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
        end
    end

    assign mode_o        = mode_q;
    assign mode_change_o = mode_change_q;
    assign lockout_o     = lockout_q;
    assign pulse_o       = pulse_q;

endmodule

// File: tb/tb_mode_input_router.sv
// Scoreboard bench for mode_input_router: each stimulus cycle pushes its expected
// outputs, which are popped and compared one edge later.
module tb_mode_input_router;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        mode_btn_i;
    logic [3:0]  btn_i;
    logic [1:0]  mode_o;
    logic        mode_change_o;
    logic        lockout_o;
    logic [11:0] pulse_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        string       name;
        logic [11:0] pulse;
        logic [1:0]  mode;
        logic        mc;
        logic        lock;
    } exp_t;

    exp_t sb_q[$];

    mode_input_router #(
        .NUM_MODES    (3),
        .NUM_BTNS     (4),
        .REPEAT_MASK  (4'b0001),
        .REPEAT_DELAY (4),
        .REPEAT_PERIOD(2)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .mode_btn_i   (mode_btn_i),
        .btn_i        (btn_i),
        .mode_o       (mode_o),
        .mode_change_o(mode_change_o),
        .lockout_o    (lockout_o),
        .pulse_o      (pulse_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string name, input logic rst, input logic mb, input logic [3:0] b,
                        input logic [11:0] ep, input logic [1:0] em, input logic emc,
                        input logic elk);
        exp_t e;
        exp_t g;
        reset_i    = rst;
        mode_btn_i = mb;
        btn_i      = b;
        e.name = name; e.pulse = ep; e.mode = em; e.mc = emc; e.lock = elk;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            g = sb_q.pop_front();
            check_eq({g.name, ".pulse"}, 32'(pulse_o), 32'(g.pulse));
            check_eq({g.name, ".mode"}, 32'(mode_o), 32'(g.mode));
            check_eq({g.name, ".mode_change"}, 32'(mode_change_o), 32'(g.mc));
            check_eq({g.name, ".lockout"}, 32'(lockout_o), 32'(g.lock));
        end
    endtask

    initial begin
        logic [11:0] ep;
        reset_i = 1'b1; mode_btn_i = 1'b0; btn_i = '0;

        step("rst0", 1, 0, 4'b0000, 12'h000, 2'd0, 0, 1);
        step("rst1", 1, 0, 4'b0000, 12'h000, 2'd0, 0, 1);

        // 1: release clears lockout, press btn1 in mode 0
        step("t1_rel",   0, 0, 4'b0000, 12'h000, 2'd0, 0, 0);
        step("t1_press", 0, 0, 4'b0010, 12'h002, 2'd0, 0, 0);
        step("t1_hold",  0, 0, 4'b0010, 12'h000, 2'd0, 0, 0);
        step("t1_idle",  0, 0, 4'b0000, 12'h000, 2'd0, 0, 0);

        // 2: mode stepping with wrap, held mode button does not step again
        step("t2_m1",    0, 1, 4'b0000, 12'h000, 2'd1, 1, 1);
        step("t2_m1r",   0, 0, 4'b0000, 12'h000, 2'd1, 0, 0);
        step("t2_m2",    0, 1, 4'b0000, 12'h000, 2'd2, 1, 1);
        step("t2_m2h",   0, 1, 4'b0000, 12'h000, 2'd2, 0, 0);
        step("t2_m2r",   0, 0, 4'b0000, 12'h000, 2'd2, 0, 0);
        step("t2_b3",    0, 0, 4'b1000, 12'h800, 2'd2, 0, 0);
        step("t2_b3r",   0, 0, 4'b0000, 12'h000, 2'd2, 0, 0);
        step("t2_m0",    0, 1, 4'b0000, 12'h000, 2'd0, 1, 1);
        step("t2_m0r",   0, 0, 4'b0000, 12'h000, 2'd0, 0, 0);

        // 3: btn0 held across a mode change stays locked out
        step("t3_b0",    0, 0, 4'b0001, 12'h001, 2'd0, 0, 0);
        step("t3_mode",  0, 1, 4'b0001, 12'h000, 2'd1, 1, 1);
        for (int i = 0; i < 7; i++)
            step("t3_held", 0, 0, 4'b0001, 12'h000, 2'd1, 0, 1);
        step("t3_rel",   0, 0, 4'b0000, 12'h000, 2'd1, 0, 0);
        step("t3_fresh", 0, 0, 4'b0001, 12'h010, 2'd1, 0, 0);
        step("t3_rel2",  0, 0, 4'b0000, 12'h000, 2'd1, 0, 0);

        // 4: auto-repeat on btn0 at k, k+4, k+6, k+8, k+10; btn1 does not repeat
        for (int i = 0; i < 12; i++) begin
            ep = (i == 0 || i == 4 || i == 6 || i == 8 || i == 10) ? 12'h010 : 12'h000;
            step("t4_rpt", 0, 0, 4'b0001, ep, 2'd1, 0, 0);
        end
        step("t4_rel",   0, 0, 4'b0000, 12'h000, 2'd1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            ep = (i == 0) ? 12'h020 : 12'h000;
            step("t4_norpt", 0, 0, 4'b0010, ep, 2'd1, 0, 0);
        end
        step("t4_rel2",  0, 0, 4'b0000, 12'h000, 2'd1, 0, 0);

        // 5: second button stops repeat; its release restarts the delay
        step("t5_b0",    0, 0, 4'b0001, 12'h010, 2'd1, 0, 0);
        step("t5_b0h",   0, 0, 4'b0001, 12'h000, 2'd1, 0, 0);
        step("t5_add2",  0, 0, 4'b0101, 12'h040, 2'd1, 0, 0);
        for (int i = 0; i < 6; i++)
            step("t5_two", 0, 0, 4'b0101, 12'h000, 2'd1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            ep = (i == 4 || i == 6) ? 12'h010 : 12'h000;
            step("t5_restart", 0, 0, 4'b0001, ep, 2'd1, 0, 0);
        end
        step("t5_rel",   0, 0, 4'b0000, 12'h000, 2'd1, 0, 0);

        // 6: simultaneous mode and button edges; reset mid-repeat
        step("t6_both",  0, 1, 4'b0010, 12'h000, 2'd2, 1, 1);
        step("t6_bh",    0, 0, 4'b0010, 12'h000, 2'd2, 0, 1);
        step("t6_rel",   0, 0, 4'b0000, 12'h000, 2'd2, 0, 0);
        for (int i = 0; i < 6; i++) begin
            ep = (i == 0 || i == 4) ? 12'h100 : 12'h000;
            step("t6_rpt", 0, 0, 4'b0001, ep, 2'd2, 0, 0);
        end
        step("t6_rst",   1, 0, 4'b0001, 12'h000, 2'd0, 0, 1);
        for (int i = 0; i < 8; i++)
            step("t6_lock", 0, 0, 4'b0001, 12'h000, 2'd0, 0, 1);
        step("t6_rel2",  0, 0, 4'b0000, 12'h000, 2'd0, 0, 0);
        step("t6_press", 0, 0, 4'b0001, 12'h001, 2'd0, 0, 0);
        step("t6_end",   0, 0, 4'b0000, 12'h000, 2'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
